mac_rx_buffer: RTL and testbench

// - Receive-side word FIFO between PCS decoder output and MAC RX frame parser.
// - Stores per-lane ctrl/data words; read side is show-ahead.
// - Frame-aware overflow: a frame that cannot fit is truncated with an XGMII error word.
// - The remainder of that frame is dropped up to and including its terminate word.

---
 rtl/mac_rx_buffer_if.sv | 30 +++
 rtl/mac_rx_buffer.sv | 148 ++++++++++++++
 tb/tb_mac_rx_buffer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mac_rx_buffer_if.sv
// rtl/mac_rx_buffer_if.sv - write/read/status bundle for the MAC RX word FIFO
interface mac_rx_buffer_if #(
  parameter int N_CHANNELS = 4,
  parameter int W_BYTE     = 8,
  parameter int DEPTH      = 16,
  parameter int W_CNT      = $clog2(DEPTH)
);
  logic                         i_clk_en;
  logic                         i_clr;
  logic                         i_wen;
  logic [N_CHANNELS-1:0]        i_wctrl;
  logic [N_CHANNELS*W_BYTE-1:0] i_wdata;
  logic                         o_full;
  logic                         i_ren;
  logic [N_CHANNELS-1:0]        o_rctrl;
  logic [N_CHANNELS*W_BYTE-1:0] o_rdata;
  logic                         o_empty;
  logic [W_CNT:0]               o_level;
  logic [15:0]                  o_drop_cnt;

  modport slave (
    input  i_clk_en, i_clr, i_wen, i_wctrl, i_wdata, i_ren,
    output o_full, o_rctrl, o_rdata, o_empty, o_level, o_drop_cnt
  );

  modport master (
    output i_clk_en, i_clr, i_wen, i_wctrl, i_wdata, i_ren,
    input  o_full, o_rctrl, o_rdata, o_empty, o_level, o_drop_cnt
  );
endinterface

// File: rtl/mac_rx_buffer.sv
// rtl/mac_rx_buffer.sv - frame-aware show-ahead RX word FIFO with overflow truncation
module mac_rx_buffer #(
  parameter int N_CHANNELS = 4,
  parameter int W_BYTE     = 8,
  parameter int DEPTH      = 16,
  parameter int W_CNT      = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  mac_rx_buffer_if.slave bus
);
  localparam int W_DATA  = N_CHANNELS * W_BYTE;
  localparam int W_ENTRY = N_CHANNELS + W_DATA;

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;

  localparam logic [W_CNT:0] LVL_RSV = (W_CNT + 1)'(DEPTH - 1);

  localparam logic [W_BYTE-1:0] B_START = W_BYTE'(8'hFB);
  localparam logic [W_BYTE-1:0] B_TERM  = W_BYTE'(8'hFD);
  localparam logic [W_BYTE-1:0] B_IDLE  = W_BYTE'(8'h07);
  localparam logic [W_BYTE-1:0] B_ERR   = W_BYTE'(8'hFE);

  localparam logic [W_ENTRY-1:0] IDLE_WORD = {{N_CHANNELS{1'b1}}, {N_CHANNELS{B_IDLE}}};
  localparam logic [W_ENTRY-1:0] ERR_WORD  = {{N_CHANNELS{1'b1}}, {N_CHANNELS{B_ERR}}};

  logic [W_CNT:0]       wptr_q, wptr_d;
  logic [W_CNT:0]       rptr_q, rptr_d;
  logic [0:0]           state_q, state_d;
  logic                 in_frame_q, in_frame_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic [W_ENTRY-1:0]   mem_q [DEPTH];

  logic [W_CNT:0]       level;
  logic [W_CNT:0]       eff;
  logic                 empty;
  logic                 rd_fire;
  logic                 is_start;
  logic                 is_term;
  logic                 wr_store;
  logic [W_ENTRY-1:0]   wr_word;
  logic [W_ENTRY-1:0]   head;

  // Occupancy, head-of-queue view and incoming word classification.
  always_comb begin
    level    = wptr_q - rptr_q;
    empty    = (level == '0);
    rd_fire  = bus.i_ren & ~empty;
    eff      = level - {{W_CNT{1'b0}}, rd_fire};
    is_start = bus.i_wctrl[0] & (bus.i_wdata[W_BYTE-1:0] == B_START);
    is_term  = 1'b0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (bus.i_wctrl[i] && bus.i_wdata[i*W_BYTE +: W_BYTE] == B_TERM) begin
        is_term = 1'b1;
      end
    end
    head = mem_q[rptr_q[W_CNT-1:0]];
  end

  // Next-state: flush, read advance, and the PASS/DROP write decision.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    state_d    = state_q;
    in_frame_d = in_frame_q;
    drop_cnt_d = drop_cnt_q;
    wr_store   = 1'b0;
    wr_word    = {bus.i_wctrl, bus.i_wdata};
    if (bus.i_clk_en) begin
      if (bus.i_clr) begin
        wptr_d     = '0;
        rptr_d     = '0;
        state_d    = ST_PASS;
        in_frame_d = 1'b0;
        drop_cnt_d = '0;
      end else begin
        if (rd_fire) begin
          rptr_d = rptr_q + 1'b1;
        end
        if (bus.i_wen) begin
          if (state_q == ST_PASS) begin
            if (eff < LVL_RSV) begin
              wr_store = 1'b1;
              if (is_term) begin
                in_frame_d = 1'b0;
              end else if (is_start) begin
                in_frame_d = 1'b1;
              end
            end else if (eff == LVL_RSV && (in_frame_q || is_start)) begin
              // The reserved last slot carries the error marker that truncates the frame.
              wr_store = 1'b1;
              wr_word  = ERR_WORD;
              if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
              end
              if (is_term) begin
                in_frame_d = 1'b0;
              end else begin
                state_d    = ST_DROP;
                in_frame_d = 1'b1;
              end
            end
          end else if (is_term) begin
            state_d    = ST_PASS;
            in_frame_d = 1'b0;
          end
        end
        if (wr_store) begin
          wptr_d = wptr_q + 1'b1;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      state_q    <= ST_PASS;
      in_frame_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      state_q    <= state_d;
      in_frame_q <= in_frame_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage; contents are don't-care until a pointer covers them.
  always_ff @(posedge i_clk) begin
    if (wr_store) begin
      mem_q[wptr_q[W_CNT-1:0]] <= wr_word;
    end
  end

  // Show-ahead outputs; the idle word stands in while empty.
  always_comb begin
    {bus.o_rctrl, bus.o_rdata} = empty ? IDLE_WORD : head;
    bus.o_empty    = empty;
    bus.o_full     = (level >= LVL_RSV);
    bus.o_level    = level;
    bus.o_drop_cnt = drop_cnt_q;
  end
endmodule

// File: tb/tb_mac_rx_buffer.sv
// tb/tb_mac_rx_buffer.sv - scoreboard bench for mac_rx_buffer
module tb_mac_rx_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [35:0] exp_q[$];

  localparam logic [35:0] START_W = {4'h1, 32'h555555FB};
  localparam logic [35:0] TERM_W  = {4'h1, 32'h070707FD};
  localparam logic [35:0] ERR_W   = {4'hF, 32'hFEFEFEFE};
  localparam logic [35:0] IDLE_W  = {4'hF, 32'h07070707};

  mac_rx_buffer_if bus ();

  mac_rx_buffer dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [35:0] w, input bit expect_store);
    bus.i_wen   = 1'b1;
    bus.i_wctrl = w[35:32];
    bus.i_wdata = w[31:0];
    if (expect_store) exp_q.push_back(w);
    step();
    bus.i_wen = 1'b0;
  endtask

  task automatic drain();
    bus.i_ren = 1'b1;
    for (int k = 0; k < 20 && !bus.o_empty; k++) step();
    bus.i_ren = 1'b0;
    check("drain_empty", {35'd0, bus.o_empty}, 36'd1);
    check("drain_queue", 36'(exp_q.size()), 36'd0);
  endtask

  // Monitor: every accepted read must present the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.i_clk_en && !bus.i_clr && bus.i_ren && !bus.o_empty) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %h expected none", {bus.o_rctrl, bus.o_rdata});
      end else begin
        check("rd_word", {bus.o_rctrl, bus.o_rdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int max_lvl;
    bus.i_clk_en = 1'b1;
    bus.i_clr    = 1'b0;
    bus.i_wen    = 1'b0;
    bus.i_ren    = 1'b0;
    bus.i_wctrl  = '0;
    bus.i_wdata  = '0;
    #12;
    check("rst_empty", {35'd0, bus.o_empty}, 36'd1);
    check("rst_full",  {35'd0, bus.o_full}, 36'd0);
    check("rst_level", 36'(bus.o_level), 36'd0);
    check("rst_idle",  {bus.o_rctrl, bus.o_rdata}, IDLE_W);
    check("rst_drop",  36'(bus.o_drop_cnt), 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Fill/drain with wrap: 40 words, reads lag by 3 cycles.
    max_lvl = 0;
    for (int c = 0; c < 46; c++) begin
      bus.i_wen   = (c < 40);
      bus.i_wctrl = 4'h0;
      bus.i_wdata = 32'h1000_0000 + 32'(c);
      bus.i_ren   = (c >= 3);
      if (c < 40) exp_q.push_back({4'h0, 32'h1000_0000 + 32'(c)});
      step();
      if (int'(bus.o_level) > max_lvl) max_lvl = int'(bus.o_level);
    end
    bus.i_wen = 1'b0;
    bus.i_ren = 1'b0;
    check("wrap_max_level", 36'(max_lvl), 36'd3);
    check("wrap_empty", {35'd0, bus.o_empty}, 36'd1);
    check("wrap_queue", 36'(exp_q.size()), 36'd0);

    // Overflow truncation: start + 20 data + term, no reads.
    put(START_W, 1'b1);
    for (int i = 0; i < 20; i++) put({4'h0, 32'hA000_0000 + 32'(i)}, i < 14);
    exp_q.push_back(ERR_W);
    put(TERM_W, 1'b0);
    check("ovf_level", 36'(bus.o_level), 36'd16);
    check("ovf_full",  {35'd0, bus.o_full}, 36'd1);
    check("ovf_drop",  36'(bus.o_drop_cnt), 36'd1);
    check("ovf_head",  {bus.o_rctrl, bus.o_rdata}, START_W);
    drain();
    check("ovf_idle", {bus.o_rctrl, bus.o_rdata}, IDLE_W);

    // Recovery: a 6-word frame passes intact.
    put(START_W, 1'b1);
    for (int i = 0; i < 4; i++) put({4'h0, 32'hB000_0000 + 32'(i)}, 1'b1);
    put(TERM_W, 1'b1);
    check("rec_level", 36'(bus.o_level), 36'd6);
    check("rec_drop",  36'(bus.o_drop_cnt), 36'd1);
    drain();

    // Same-cycle read/write at level 15 mid-frame.
    put(START_W, 1'b1);
    for (int i = 0; i < 14; i++) put({4'h0, 32'hC000_0000 + 32'(i)}, 1'b1);
    check("rw_pre_level", 36'(bus.o_level), 36'd15);
    bus.i_ren = 1'b1;
    put({4'h0, 32'hC0DE_0001}, 1'b1);
    bus.i_ren = 1'b0;
    check("rw_level", 36'(bus.o_level), 36'd15);
    check("rw_drop",  36'(bus.o_drop_cnt), 36'd1);
    put({4'h0, 32'hC0DE_0002}, 1'b0);
    exp_q.push_back(ERR_W);
    check("rw_ovf_level", 36'(bus.o_level), 36'd16);
    check("rw_ovf_drop",  36'(bus.o_drop_cnt), 36'd2);

    // Clock enable low freezes everything.
    bus.i_clk_en = 1'b0;
    bus.i_ren    = 1'b1;
    put({4'h0, 32'hDEAD_0001}, 1'b0);
    bus.i_ren    = 1'b0;
    bus.i_clk_en = 1'b1;
    check("cen_level", 36'(bus.o_level), 36'd16);
    check("cen_drop",  36'(bus.o_drop_cnt), 36'd2);

    // Clear wins over simultaneous read and write.
    bus.i_clr = 1'b1;
    bus.i_ren = 1'b1;
    put({4'h0, 32'hDEAD_0002}, 1'b0);
    bus.i_clr = 1'b0;
    bus.i_ren = 1'b0;
    exp_q.delete();
    check("clr_level", 36'(bus.o_level), 36'd0);
    check("clr_drop",  36'(bus.o_drop_cnt), 36'd0);
    check("clr_idle",  {bus.o_rctrl, bus.o_rdata}, IDLE_W);
    put({4'h0, 32'hE000_0001}, 1'b1);
    check("clr_pass_store", 36'(bus.o_level), 36'd1);
    drain();

    // Asynchronous reset mid-stream with 5 entries.
    for (int i = 0; i < 5; i++) put({4'h0, 32'hF000_0000 + 32'(i)}, 1'b0);
    check("arst_pre_level", 36'(bus.o_level), 36'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", {35'd0, bus.o_empty}, 36'd1);
    check("arst_level", 36'(bus.o_level), 36'd0);
    check("arst_idle",  {bus.o_rctrl, bus.o_rdata}, IDLE_W);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_hold_level", 36'(bus.o_level), 36'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
